// File: rtl/traffic_light_fsm.sv
// Traffic light sequencer: selects the phase interval from the time-parameter store,
// counts it down on 1 Hz ticks and drives the main/side/walk lamps.
module traffic_light_fsm #(
  parameter int unsigned TIMER_W  = 4,
  parameter logic [1:0]  INT_BASE = 2'b00,
  parameter logic [1:0]  INT_EXT  = 2'b01,
  parameter logic [1:0]  INT_YEL  = 2'b10
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               one_hz_enable,
  input  logic               sensor_sync,
  input  logic               walk_request,
  input  logic               prog_sync,
  input  logic [TIMER_W-1:0] value,
  output logic [1:0]         interval,
  output logic [2:0]         main_lights,
  output logic [2:0]         side_lights,
  output logic               walk_lamp,
  output logic [TIMER_W-1:0] timer_count
);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    S_MG1  = 3'd0,
    S_MG2  = 3'd1,
    S_MY   = 3'd2,
    S_WALK = 3'd3,
    S_SG   = 3'd4,
    S_SGX  = 3'd5,
    S_SY   = 3'd6
  } state_e;

  typedef struct packed {
    logic [1:0] intv;
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
  } lamp_t;

  localparam lamp_t RESET_OUT = '{intv: INT_BASE, main: LAMP_G, side: LAMP_R, walk: 1'b0};

  state_e               state_q, state_d, state_nxt;
  logic                 load_pending_q, load_pending_d;
  logic                 walk_pending_q, walk_pending_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  lamp_t                out_q, out_d;

  // Lamp and interval decode for a state being entered; MG2 picks its interval from the sensor.
  function automatic lamp_t decode(input state_e s, input logic sensor);
    lamp_t o;
    o = RESET_OUT;
    case (s)
      S_MG1:   o = '{intv: INT_BASE, main: LAMP_G, side: LAMP_R, walk: 1'b0};
      S_MG2:   o = '{intv: (sensor ? INT_EXT : INT_BASE), main: LAMP_G, side: LAMP_R, walk: 1'b0};
      S_MY:    o = '{intv: INT_YEL,  main: LAMP_Y, side: LAMP_R, walk: 1'b0};
      S_WALK:  o = '{intv: INT_EXT,  main: LAMP_R, side: LAMP_R, walk: 1'b1};
      S_SG:    o = '{intv: INT_BASE, main: LAMP_R, side: LAMP_G, walk: 1'b0};
      S_SGX:   o = '{intv: INT_EXT,  main: LAMP_R, side: LAMP_G, walk: 1'b0};
      S_SY:    o = '{intv: INT_YEL,  main: LAMP_R, side: LAMP_Y, walk: 1'b0};
      default: o = RESET_OUT;
    endcase
    return o;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_MG1;
      load_pending_q <= 1'b1;
      walk_pending_q <= 1'b0;
      timer_q        <= '0;
      out_q          <= RESET_OUT;
    end else begin
      state_q        <= state_d;
      load_pending_q <= load_pending_d;
      walk_pending_q <= walk_pending_d;
      timer_q        <= timer_d;
      out_q          <= out_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_pending_d = load_pending_q;
    walk_pending_d = walk_pending_q | walk_request;
    timer_d        = timer_q;
    out_d          = out_q;
    state_nxt      = state_q;

    case (state_q)
      S_MG1:   state_nxt = S_MG2;
      S_MG2:   state_nxt = S_MY;
      S_MY:    state_nxt = walk_pending_q ? S_WALK : S_SG;
      S_WALK:  state_nxt = S_SG;
      S_SG:    state_nxt = sensor_sync ? S_SGX : S_SY;
      S_SGX:   state_nxt = S_SY;
      S_SY:    state_nxt = S_MG1;
      default: state_nxt = S_MG1;
    endcase

    if (prog_sync) begin
      state_d        = S_MG1;
      load_pending_d = 1'b1;
      timer_d        = '0;
      out_d          = RESET_OUT;
    end else if (load_pending_q) begin
      // A zero duration still gives one tick so the phase cannot stall or underflow.
      timer_d        = (value == '0) ? TIMER_W'(1) : value;
      load_pending_d = 1'b0;
    end else if (one_hz_enable && (timer_q != '0)) begin
      if (timer_q == TIMER_W'(1)) begin
        state_d        = state_nxt;
        load_pending_d = 1'b1;
        timer_d        = '0;
        out_d          = decode(state_nxt, sensor_sync);
        if ((state_nxt == S_WALK) && !walk_request) begin
          walk_pending_d = 1'b0;
        end
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end
  end

  assign interval    = out_q.intv;
  assign main_lights = out_q.main;
  assign side_lights = out_q.side;
  assign walk_lamp   = out_q.walk;
  assign timer_count = timer_q;

  a_one_lamp_per_street: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot(main_lights) && $onehot(side_lights));

  a_no_conflicting_green: assert property (@(posedge clock) disable iff (!reset_n)
    (main_lights == LAMP_R) || (side_lights == LAMP_R));

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with a behavioural time-parameter store.
module tb_traffic_light_fsm;

  localparam int unsigned TW = 4;

  localparam logic [8:0] SIG_MG   = {3'b001, 3'b100, 1'b0, 2'b00};
  localparam logic [8:0] SIG_MG2X = {3'b001, 3'b100, 1'b0, 2'b01};
  localparam logic [8:0] SIG_MY   = {3'b010, 3'b100, 1'b0, 2'b10};
  localparam logic [8:0] SIG_WALK = {3'b100, 3'b100, 1'b1, 2'b01};
  localparam logic [8:0] SIG_SG   = {3'b100, 3'b001, 1'b0, 2'b00};
  localparam logic [8:0] SIG_SGX  = {3'b100, 3'b001, 1'b0, 2'b01};
  localparam logic [8:0] SIG_SY   = {3'b100, 3'b010, 1'b0, 2'b10};

  logic          clock;
  logic          reset_n;
  logic          one_hz_enable;
  logic          sensor_sync;
  logic          walk_request;
  logic          prog_sync;
  logic [TW-1:0] value;
  logic [1:0]    interval;
  logic [2:0]    main_lights;
  logic [2:0]    side_lights;
  logic          walk_lamp;
  logic [TW-1:0] timer_count;

  logic [TW-1:0] base_v, ext_v, yel_v;
  int            asserts;
  int            fails;

  traffic_light_fsm #(.TIMER_W(TW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .one_hz_enable (one_hz_enable),
    .sensor_sync   (sensor_sync),
    .walk_request  (walk_request),
    .prog_sync     (prog_sync),
    .value         (value),
    .interval      (interval),
    .main_lights   (main_lights),
    .side_lights   (side_lights),
    .walk_lamp     (walk_lamp),
    .timer_count   (timer_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational store lookup
  always_comb begin
    case (interval)
      2'b00:   value = base_v;
      2'b01:   value = ext_v;
      2'b10:   value = yel_v;
      default: value = '0;
    endcase
  end

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Starting on a load-cycle sample, returns the phase signature, its length in clocks
  // (-1 on timeout) and the largest timer value seen.
  task automatic wait_phase(output int cycles, output logic [8:0] sig, output logic [TW-1:0] tmax);
    sig    = {main_lights, side_lights, walk_lamp, interval};
    cycles = 0;
    tmax   = '0;
    do begin
      @(negedge clock);
      cycles++;
      if (timer_count > tmax) tmax = timer_count;
    end while (timer_count != '0 && cycles < 64);
    if (timer_count != '0) cycles = -1;
  endtask

  task automatic test_reset();
    do_reset();
    asserts++; if (main_lights !== 3'b001) begin fails++; $display("FAIL reset_main: got %b expected 001", main_lights); end
    asserts++; if (side_lights !== 3'b100) begin fails++; $display("FAIL reset_side: got %b expected 100", side_lights); end
    asserts++; if (walk_lamp !== 1'b0) begin fails++; $display("FAIL reset_walk: got %b expected 0", walk_lamp); end
    asserts++; if (interval !== 2'b00) begin fails++; $display("FAIL reset_interval: got %b expected 00", interval); end
    asserts++; if (timer_count !== 4'd0) begin fails++; $display("FAIL reset_timer: got %0d expected 0", timer_count); end
    @(negedge clock);
    asserts++; if (timer_count !== 4'd6) begin fails++; $display("FAIL reset_first_load: got %0d expected 6", timer_count); end
  endtask

  task automatic test_normal_cycle();
    logic [8:0]    es [5] = '{SIG_MG, SIG_MG, SIG_MY, SIG_SG, SIG_SY};
    int            el [5] = '{7, 7, 3, 7, 3};
    int            cyc;
    logic [8:0]    sig;
    logic [TW-1:0] tm;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_phase(cyc, sig, tm);
      asserts++; if (sig !== es[i]) begin fails++; $display("FAIL normal_sig[%0d]: got %b expected %b", i, sig, es[i]); end
      asserts++; if (cyc != el[i]) begin fails++; $display("FAIL normal_len[%0d]: got %0d expected %0d", i, cyc, el[i]); end
    end
    asserts++; if ({main_lights, side_lights, walk_lamp, interval} !== SIG_MG) begin
      fails++; $display("FAIL normal_wrap: got %b expected %b", {main_lights, side_lights, walk_lamp, interval}, SIG_MG); end
  endtask

  task automatic test_sensor();
    logic [8:0]    es [6] = '{SIG_MG, SIG_MG2X, SIG_MY, SIG_SG, SIG_SGX, SIG_SY};
    int            el [6] = '{7, 4, 3, 7, 4, 3};
    int            cyc;
    logic [8:0]    sig;
    logic [TW-1:0] tm;
    sensor_sync = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wait_phase(cyc, sig, tm);
      asserts++; if (sig !== es[i]) begin fails++; $display("FAIL sensor_sig[%0d]: got %b expected %b", i, sig, es[i]); end
      asserts++; if (cyc != el[i]) begin fails++; $display("FAIL sensor_len[%0d]: got %0d expected %0d", i, cyc, el[i]); end
    end
    sensor_sync = 1'b0;
  endtask

  task automatic test_walk();
    logic [8:0]    es [16] = '{SIG_MG, SIG_MG, SIG_WALK, SIG_SG, SIG_SY, SIG_MG, SIG_MG, SIG_MY,
                               SIG_WALK, SIG_SG, SIG_SY, SIG_MG, SIG_MG, SIG_MY, SIG_SG, SIG_SY};
    int            el [16] = '{7, 7, 4, 7, 3, 7, 7, 3, 4, 7, 3, 7, 7, 3, 7, 3};
    int            cyc;
    logic [8:0]    sig;
    logic [TW-1:0] tm;
    do_reset();
    walk_request = 1'b1;
    @(negedge clock);
    walk_request = 1'b0;
    // Finish MG1 (already one clock in) and run MG2
    do begin @(negedge clock); end while (timer_count != '0);
    wait_phase(cyc, sig, tm);
    // First MY: second walk pulse lands on the WALK entry edge
    asserts++; if ({main_lights, side_lights, walk_lamp, interval} !== SIG_MY) begin
      fails++; $display("FAIL walk_my_sig: got %b expected %b", {main_lights, side_lights, walk_lamp, interval}, SIG_MY); end
    repeat (2) @(negedge clock);
    asserts++; if (timer_count !== 4'd1) begin fails++; $display("FAIL walk_my_timer: got %0d expected 1", timer_count); end
    walk_request = 1'b1;
    @(negedge clock);
    walk_request = 1'b0;
    for (int i = 2; i < 16; i++) begin
      wait_phase(cyc, sig, tm);
      asserts++; if (sig !== es[i]) begin fails++; $display("FAIL walk_sig[%0d]: got %b expected %b", i, sig, es[i]); end
      asserts++; if (cyc != el[i]) begin fails++; $display("FAIL walk_len[%0d]: got %0d expected %0d", i, cyc, el[i]); end
    end
  endtask

  task automatic test_zero_value();
    logic [8:0]    es [5] = '{SIG_MG, SIG_MG, SIG_MY, SIG_SG, SIG_SY};
    int            el [5] = '{2, 2, 3, 2, 3};
    int            cyc;
    logic [8:0]    sig;
    logic [TW-1:0] tm;
    base_v = '0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_phase(cyc, sig, tm);
      asserts++; if (sig !== es[i]) begin fails++; $display("FAIL zero_sig[%0d]: got %b expected %b", i, sig, es[i]); end
      asserts++; if (cyc != el[i]) begin fails++; $display("FAIL zero_len[%0d]: got %0d expected %0d", i, cyc, el[i]); end
      if (i == 0) begin
        asserts++; if (tm !== 4'd1) begin fails++; $display("FAIL zero_max_timer: got %0d expected 1", tm); end
      end
    end
    base_v = 4'd6;
  endtask

  task automatic test_prog();
    int            cyc;
    logic [8:0]    sig;
    logic [TW-1:0] tm;
    do_reset();
    repeat (3) wait_phase(cyc, sig, tm);
    asserts++; if ({main_lights, side_lights, walk_lamp, interval} !== SIG_SG) begin
      fails++; $display("FAIL prog_sg_sig: got %b expected %b", {main_lights, side_lights, walk_lamp, interval}, SIG_SG); end
    repeat (3) @(negedge clock);
    asserts++; if (timer_count !== 4'd4) begin fails++; $display("FAIL prog_timer4: got %0d expected 4", timer_count); end
    prog_sync = 1'b1;
    @(negedge clock);
    prog_sync = 1'b0;
    asserts++; if ({main_lights, side_lights, walk_lamp, interval} !== SIG_MG) begin
      fails++; $display("FAIL prog_restart_sig: got %b expected %b", {main_lights, side_lights, walk_lamp, interval}, SIG_MG); end
    asserts++; if (timer_count !== 4'd0) begin fails++; $display("FAIL prog_restart_timer: got %0d expected 0", timer_count); end
    wait_phase(cyc, sig, tm);
    asserts++; if (cyc != 7) begin fails++; $display("FAIL prog_mg1_len: got %0d expected 7", cyc); end
    // Held strobe coinciding with expiry of SG
    repeat (2) wait_phase(cyc, sig, tm);
    repeat (6) @(negedge clock);
    asserts++; if (timer_count !== 4'd1) begin fails++; $display("FAIL prog_timer1: got %0d expected 1", timer_count); end
    prog_sync = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      asserts++; if ({main_lights, side_lights, walk_lamp, interval, timer_count} !== {SIG_MG, 4'd0}) begin
        fails++; $display("FAIL prog_hold[%0d]: got %b expected %b", k, {main_lights, side_lights, walk_lamp, interval, timer_count}, {SIG_MG, 4'd0}); end
    end
    prog_sync = 1'b0;
    wait_phase(cyc, sig, tm);
    asserts++; if (cyc != 7) begin fails++; $display("FAIL prog_hold_len: got %0d expected 7", cyc); end
  endtask

  task automatic test_async_reset();
    int            cyc;
    logic [8:0]    sig;
    logic [TW-1:0] tm;
    int            cnt;
    do_reset();
    repeat (2) wait_phase(cyc, sig, tm);
    @(negedge clock);
    asserts++; if ({main_lights, timer_count} !== {3'b010, 4'd2}) begin
      fails++; $display("FAIL areset_pre: got %b expected %b", {main_lights, timer_count}, {3'b010, 4'd2}); end
    #1 reset_n = 1'b0;
    #1;
    asserts++; if ({main_lights, side_lights, walk_lamp, interval, timer_count} !== {SIG_MG, 4'd0}) begin
      fails++; $display("FAIL areset_now: got %b expected %b", {main_lights, side_lights, walk_lamp, interval, timer_count}, {SIG_MG, 4'd0}); end
    #2 reset_n = 1'b1;
    cnt = 0;
    do begin @(negedge clock); cnt++; end while (timer_count != '0 && cnt < 64);
    asserts++; if (cnt != 7) begin fails++; $display("FAIL areset_mg1_len: got %0d expected 7", cnt); end
  endtask

  initial begin
    asserts       = 0;
    fails         = 0;
    reset_n       = 1'b0;
    one_hz_enable = 1'b1;
    sensor_sync   = 1'b0;
    walk_request  = 1'b0;
    prog_sync     = 1'b0;
    base_v        = 4'd6;
    ext_v         = 4'd3;
    yel_v         = 4'd2;
    test_reset();
    test_normal_cycle();
    test_sensor();
    test_walk();
    test_zero_value();
    test_prog();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Sequencing controller for the traffic light datapath.
- Drives the interval selector of the time-parameter store and reads back the selected duration value.
- Counts that duration down on 1 Hz enable ticks and steps the main/side/walk light outputs through the cycle.
- Sits between the input synchronisers (sensor, walk, prog), the 1 Hz divider and the time-parameter store.

Parameters:
TIMER_W, 4, width of the duration value and of the internal countdown counter
INT_BASE, 2'b00, interval code for the base duration
INT_EXT, 2'b01, interval code for the extended duration
INT_YEL, 2'b10, interval code for the yellow duration

Ports:
clock  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
one_hz_enable  in  1  single-cycle tick, one per second
sensor_sync  in  1  synchronised side-street vehicle sensor
walk_request  in  1  synchronised walk button, single-cycle pulse
prog_sync  in  1  synchronised reprogram strobe; restarts the cycle
value  in  TIMER_W  duration returned for the current interval (combinational lookup in the store)
interval  out  2  interval code presented to the store
main_lights  out  3  {red, yellow, green} for the main street
side_lights  out  3  {red, yellow, green} for the side street
walk_lamp  out  1  pedestrian walk indicator
timer_count  out  TIMER_W  remaining ticks in the current phase (debug)

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=MG1, load_pending=1, walk_pending=0, timer_count=0, interval=INT_BASE.
  - main_lights=3'b001, side_lights=3'b100, walk_lamp=0.
- States, lights and interval:
  - MG1: main G, side R, interval BASE.
  - MG2: main G, side R, interval EXT if sensor_sync=1 on the load cycle, else BASE.
  - MY: main Y, side R, interval YEL.
  - WALK: main R, side R, walk_lamp=1, interval EXT.
  - SG: main R, side G, interval BASE.
  - SGX: main R, side G, interval EXT.
  - SY: main R, side Y, interval YEL.
- interval, main_lights, side_lights and walk_lamp are registered and decoded from the state; MG2's interval choice is latched on its load cycle.
- Phase timing:
  - On entering any state, load_pending=1.
  - On the next clock edge, timer_count <= value (the value is valid because interval is already stable), or <= 1 if value=0. load_pending then clears.
  - While load_pending=0, each one_hz_enable decrements timer_count.
  - A tick with timer_count=1 is expiry: transition to the next state on that edge, timer_count -> 0.
  - Ticks during the load cycle are ignored.
  - Phase duration is therefore value ticks, plus one clock of load.
- Transitions on expiry:
  - MG1 -> MG2 -> MY.
  - MY -> WALK if walk_pending, else SG.
  - WALK -> SG; walk_pending clears on entry to WALK.
  - SG -> SGX if sensor_sync=1 at expiry, else SY.
  - SGX -> SY -> MG1.
- walk_request=1 sets walk_pending in any state. If it coincides with the WALK entry edge, the set wins and the walk is served on the next cycle.
- prog_sync=1: synchronous restart with the same values as reset, except walk_pending, which is kept. prog_sync takes priority over expiry on the same edge. While prog_sync is held, the block stays in MG1 with load_pending=1.
- Mid-phase changes of value (store reprogrammed) do not affect the running count; they take effect at the next load.
- Asserting reset mid-phase aborts immediately to the reset values.
- Exactly one lamp per street is lit in every state. main and side are never both non-red.

Test Plan:
- Store defaults base=6, ext=3, yel=2; one_hz_enable every cycle; sensor=0, no walk.
  - Sequence MG1(6) MG2(6) MY(2) SG(6) SY(2) MG1.
  - Each phase lasts value+1 clocks.
  - interval sequence 00,00,10,00,10.
- sensor_sync=1 throughout -> MG2 uses ext (3 ticks); SG is followed by SGX (3 ticks, side green), then SY.
- walk_request pulse during MG1 -> after MY: WALK for 3 ticks, lights main=100 side=100 walk_lamp=1, then SG. walk_pending=0 afterwards; the next cycle has no WALK.
- value=0 (base reprogrammed to 0) -> MG1 lasts exactly 1 tick; no underflow, timer_count never wraps to 15.
- prog_sync pulse in SG with timer_count=4 -> next edge state=MG1, main=001, side=100, reload from base. A simultaneous expiry is ignored.
- reset_n low for 3 ns between clock edges during MY -> outputs go to reset values without waiting for a clock edge. After release, the full MG1 phase runs again.
